// File: rtl/gray_sync_decoder.sv
// Brings a gray-coded count across a clock boundary, decodes it to binary and reports the
// per-cycle step, a change pulse and a sticky multi-bit-step error once the pipeline is armed.
module gray_sync_decoder #(
  parameter int unsigned W      = 4,
  parameter int unsigned N_SYNC = 2
) (
  input  logic         clk,
  input  logic         areset_n,
  input  logic [W-1:0] gray_in,
  input  logic         err_clr,
  output logic [W-1:0] bin_out,
  output logic         changed,
  output logic [W-1:0] delta,
  output logic         err,
  output logic         armed
);

  localparam int unsigned CW = $clog2(N_SYNC + 1) + 1;

  localparam logic [0:0] ST_ARM = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;

  logic [N_SYNC-1:0][W-1:0] r_sync;
  logic [W-1:0]             r_g_prev;
  logic [W-1:0]             r_bin;
  logic                     r_changed;
  logic [W-1:0]             r_delta;
  logic                     r_err;
  logic [CW-1:0]            r_arm_cnt;
  logic [0:0]               r_state;

  logic [W-1:0] w_g_sync;
  logic [W-1:0] w_bin_sync;
  logic [W-1:0] w_bin_prev;
  logic [W-1:0] w_diff;
  logic         w_multi;
  logic         w_run;

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign w_g_sync   = r_sync[N_SYNC-1];
  assign w_bin_sync = gray2bin(w_g_sync);
  assign w_bin_prev = gray2bin(r_g_prev);
  assign w_diff     = w_g_sync ^ r_g_prev;
  // Clearing the lowest set bit leaves something only if two or more bits flipped.
  assign w_multi    = (w_diff & (w_diff - W'(1))) != '0;
  assign w_run      = (r_state == ST_RUN);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_sync    <= '0;
      r_g_prev  <= '0;
      r_bin     <= '0;
      r_changed <= 1'b0;
      r_delta   <= '0;
      r_err     <= 1'b0;
      r_arm_cnt <= '0;
      r_state   <= ST_ARM;
    end else begin
      r_sync    <= {r_sync[N_SYNC-2:0], gray_in};
      r_g_prev  <= w_g_sync;
      r_bin     <= w_bin_sync;
      r_changed <= w_run && (w_g_sync != r_g_prev);
      r_delta   <= w_run ? (w_bin_sync - w_bin_prev) : '0;
      // A new multi-bit step takes priority over a clear in the same cycle.
      r_err     <= (w_run && w_multi) || (r_err && !err_clr);
      if (r_state == ST_ARM) begin
        if (r_arm_cnt == CW'(N_SYNC)) begin
          r_state <= ST_RUN;
        end else begin
          r_arm_cnt <= r_arm_cnt + CW'(1);
        end
      end
    end
  end

  assign bin_out = r_bin;
  assign changed = r_changed;
  assign delta   = r_delta;
  assign err     = r_err;
  assign armed   = w_run;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Self-checking bench for gray_sync_decoder: directed scenarios plus a randomized gray walk,
// compared against a history-based reference model.
module tb_gray_sync_decoder;

  localparam int unsigned W = 4;
  localparam int unsigned N = 2;

  logic         clk;
  logic         areset_n;
  logic [W-1:0] gray_in;
  logic         err_clr;
  logic [W-1:0] bin_out;
  logic         changed;
  logic [W-1:0] delta;
  logic         err;
  logic         armed;

  int checks = 0;
  int errors = 0;

  // Reference model: every sampled input since reset release, plus derived expectations.
  int           t;
  logic [W-1:0] ghist[$];
  logic [W-1:0] m_bin;
  logic [W-1:0] m_delta;
  logic         m_changed;
  logic         m_err;
  logic         m_armed;
  int           cur;

  gray_sync_decoder #(
    .W      (W),
    .N_SYNC (N)
  ) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .gray_in  (gray_in),
    .err_clr  (err_clr),
    .bin_out  (bin_out),
    .changed  (changed),
    .delta    (delta),
    .err      (err),
    .armed    (armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] b2g(input int b);
    return W'(b ^ (b >> 1));
  endfunction

  // Decode by searching the encoding table rather than by bitwise prefix XOR.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    for (int b = 0; b < (1 << W); b++) begin
      if (b2g(b) == g) return W'(b);
    end
    return '0;
  endfunction

  task automatic model_reset();
    t = 0;
    ghist.delete();
    m_bin     = '0;
    m_delta   = '0;
    m_changed = 1'b0;
    m_err     = 1'b0;
    m_armed   = 1'b0;
  endtask

  task automatic tick(input logic [W-1:0] g, input logic clr);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         set;
    gray_in = g;
    err_clr = clr;
    @(posedge clk);
    t++;
    ghist.push_back(g);
    m_armed = (t >= N + 1);
    m_bin   = (t >= N + 1) ? g2b(ghist[t-N-1]) : '0;
    set     = 1'b0;
    if (t >= N + 2) begin
      a         = ghist[t-N-1];
      b         = ghist[t-N-2];
      m_changed = (a != b);
      m_delta   = g2b(a) - g2b(b);
      set       = ($countones(a ^ b) > 1);
    end else begin
      m_changed = 1'b0;
      m_delta   = '0;
    end
    m_err = set | (m_err & ~clr);
    #1;
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    gray_in  = '0;
    err_clr  = 1'b0;
    #12;
    checks++;
    if ({bin_out, changed, delta, err, armed} !== '0) begin
      errors++;
      $display("FAIL reset_state got %0h exp 0", {bin_out, changed, delta, err, armed});
    end
    areset_n = 1'b1;
    model_reset();
    cur = 0;
    for (int i = 1; i <= 5; i++) begin
      tick('0, 1'b0);
      checks++;
      if (armed !== (i >= 3)) begin
        errors++;
        $display("FAIL arm_edge%0d got %0b exp %0b", i, armed, (i >= 3));
      end
      checks++;
      if ({changed, err, bin_out} !== '0) begin
        errors++;
        $display("FAIL arm_quiet%0d got %0h exp 0", i, {changed, err, bin_out});
      end
    end
  endtask

  task automatic test_walk();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) cur = (cur + 1) % (1 << W);
      tick(b2g(cur), 1'b0);
      checks++;
      if (bin_out !== m_bin) begin
        errors++;
        $display("FAIL walk_bin%0d got %0h exp %0h", i, bin_out, m_bin);
      end
      if (i >= 2) begin
        checks++;
        if ({changed, delta, err} !== {1'b1, W'(1), 1'b0}) begin
          errors++;
          $display("FAIL walk_step%0d got c=%0b d=%0h e=%0b exp c=1 d=1 e=0",
                   i, changed, delta, err);
        end
      end
    end
  endtask

  task automatic test_wrap();
    while (cur != (1 << W) - 1) begin
      cur = cur + 1;
      tick(b2g(cur), 1'b0);
      checks++;
      if ({bin_out, changed, delta} !== {m_bin, m_changed, m_delta}) begin
        errors++;
        $display("FAIL wrap_walk got %0h exp %0h", {bin_out, changed, delta},
                 {m_bin, m_changed, m_delta});
      end
    end
    for (int i = 0; i < 3; i++) tick(b2g(cur), 1'b0);
    checks++;
    if ({bin_out, changed} !== {4'hf, 1'b0}) begin
      errors++;
      $display("FAIL wrap_max got b=%0h c=%0b exp b=f c=0", bin_out, changed);
    end
    cur = 0;
    for (int i = 0; i < 3; i++) tick('0, 1'b0);
    checks++;
    if ({bin_out, changed, delta, err} !== {4'h0, 1'b1, 4'h1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_zero got b=%0h c=%0b d=%0h e=%0b exp b=0 c=1 d=1 e=0",
               bin_out, changed, delta, err);
    end
    tick('0, 1'b0);
  endtask

  task automatic test_jump_err();
    for (int i = 0; i < 3; i++) tick(4'b0011, 1'b0);
    checks++;
    if ({bin_out, changed, delta, err} !== {4'h2, 1'b1, 4'h2, 1'b1}) begin
      errors++;
      $display("FAIL jump_step got b=%0h c=%0b d=%0h e=%0b exp b=2 c=1 d=2 e=1",
               bin_out, changed, delta, err);
    end
    for (int i = 0; i < 3; i++) begin
      tick(4'b0011, 1'b0);
      checks++;
      if ({err, changed} !== 2'b10) begin
        errors++;
        $display("FAIL err_hold%0d got e=%0b c=%0b exp e=1 c=0", i, err, changed);
      end
    end
    tick(4'b0011, 1'b1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr got %0b exp 0", err);
    end
    tick('0, 1'b0);
    tick('0, 1'b0);
    tick('0, 1'b1);
    checks++;
    if ({err, changed, delta} !== {1'b1, 1'b1, 4'he}) begin
      errors++;
      $display("FAIL set_wins got e=%0b c=%0b d=%0h exp e=1 c=1 d=e", err, changed, delta);
    end
    checks++;
    if (err !== m_err) begin
      errors++;
      $display("FAIL set_wins_model got %0b exp %0b", err, m_err);
    end
    tick('0, 1'b1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr2 got %0b exp 0", err);
    end
    cur = 0;
  endtask

  task automatic test_hold();
    // Jump 0000 -> 0110 is two bits, so err is left set going into the hold.
    cur = 4;
    for (int i = 0; i < 3; i++) tick(4'b0110, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(4'b0110, 1'b0);
      checks++;
      if ({bin_out, changed, delta, err} !== {4'h4, 1'b0, 4'h0, m_err}) begin
        errors++;
        $display("FAIL hold%0d got b=%0h c=%0b d=%0h e=%0b exp b=4 c=0 d=0 e=%0b",
                 i, bin_out, changed, delta, err, m_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    cur = 5;
    for (int i = 0; i < 3; i++) tick(4'b0111, 1'b0);
    checks++;
    if ({bin_out, changed, err, armed} !== {4'h5, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset got b=%0h c=%0b e=%0b a=%0b exp b=5 c=1 e=1 a=1",
               bin_out, changed, err, armed);
    end
    #1 areset_n = 1'b0;
    #1;
    checks++;
    if ({bin_out, changed, delta, err, armed} !== '0) begin
      errors++;
      $display("FAIL async_reset got %0h exp 0", {bin_out, changed, delta, err, armed});
    end
    #2 areset_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 6; i++) begin
      tick(4'b0111, 1'b0);
      checks++;
      if ({armed, changed, err} !== {(i >= 3), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rearm%0d got a=%0b c=%0b e=%0b exp a=%0b c=0 e=0",
                 i, armed, changed, err, (i >= 3));
      end
      checks++;
      if (bin_out !== m_bin) begin
        errors++;
        $display("FAIL rearm_bin%0d got %0h exp %0h", i, bin_out, m_bin);
      end
    end
  endtask

  task automatic test_random();
    int r;
    logic clr;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      cur = (cur + 1) % (1 << W);
      else if (r <= 6) cur = (cur + (1 << W) - 1) % (1 << W);
      else if (r >= 8) cur = $urandom_range(0, (1 << W) - 1);
      clr = ($urandom_range(0, 7) == 0);
      tick(b2g(cur), clr);
      checks++;
      if (bin_out !== m_bin) begin
        errors++;
        $display("FAIL rnd_bin%0d got %0h exp %0h", i, bin_out, m_bin);
      end
      checks++;
      if (changed !== m_changed) begin
        errors++;
        $display("FAIL rnd_changed%0d got %0b exp %0b", i, changed, m_changed);
      end
      checks++;
      if (delta !== m_delta) begin
        errors++;
        $display("FAIL rnd_delta%0d got %0h exp %0h", i, delta, m_delta);
      end
      checks++;
      if (err !== m_err) begin
        errors++;
        $display("FAIL rnd_err%0d got %0b exp %0b", i, err, m_err);
      end
      checks++;
      if (armed !== m_armed) begin
        errors++;
        $display("FAIL rnd_armed%0d got %0b exp %0b", i, armed, m_armed);
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk();
    test_wrap();
    test_jump_err();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
